// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers
// (pixel source and video DAC).
interface vga_timing_gen_if #(
  parameter int unsigned CW = 12
);
  logic          enable;
  logic          pix_ce;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic          vga_HSYNC;
  logic          vga_VSYNC;
  logic          vga_BLANK_n;
  logic          vga_CLOCK;

  // Timing generator side: takes the run enable, drives raster timing.
  modport master (
    input  enable,
    output pix_ce, x, y, active, line_start, frame_start,
    output vga_HSYNC, vga_VSYNC, vga_BLANK_n, vga_CLOCK
  );

  // Consumer side: pixel source / DAC.
  modport slave (
    output enable,
    input  pix_ce, x, y, active, line_start, frame_start,
    input  vga_HSYNC, vga_VSYNC, vga_BLANK_n, vga_CLOCK
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock enable divider,
// horizontal/vertical counters, coordinate export and a sync/blank delay
// pipeline that lines the DAC controls up with downstream RGB latency.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned PIPE     = 2,
  parameter int unsigned CW       = 12
) (
  input logic              CLOCKINPUT,
  input logic              PLD_RESET_N,
  vga_timing_gen_if.master vif
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LAST     = PIPE - 1;

  // Pipeline element layout: {hsync level, vsync level, blank_n}.
  localparam logic [2:0] IDLE_LVL = {~HS_POL, ~VS_POL, 1'b0};

  logic [DW-1:0] d;
  logic [DW-1:0] d_next;
  logic          vga_clk_q;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          ce;
  logic          at_last_x;
  logic          at_last_y;
  logic          hs_c;
  logic          vs_c;
  logic          act_c;
  logic [2:0]    lvl_c;
  logic [2:0]    pipe_q [PIPE];

  // Divider wrap and raster decode from the registered counters.
  always_comb begin
    d_next    = (d == DW'(CLK_DIV - 1)) ? '0 : d + DW'(1);
    ce        = (d == DW'(CLK_DIV - 1)) && vif.enable;
    at_last_x = (x == CW'(H_TOTAL - 1));
    at_last_y = (y == CW'(V_TOTAL - 1));
    hs_c      = (x >= CW'(HS_START)) && (x < CW'(HS_END));
    vs_c      = (y >= CW'(VS_START)) && (y < CW'(VS_END));
    act_c     = (x < CW'(H_ACTIVE)) && (y < CW'(V_ACTIVE));
    lvl_c     = {hs_c ? HS_POL : ~HS_POL, vs_c ? VS_POL : ~VS_POL, act_c};
  end

  // Pixel divider; DAC clock is high in the second half of each pixel.
  always_ff @(posedge CLOCKINPUT) begin
    if (!PLD_RESET_N) begin
      d         <= '0;
      vga_clk_q <= 1'b0;
    end else if (vif.enable) begin
      d         <= d_next;
      vga_clk_q <= (d_next >= DW'(CLK_DIV / 2));
    end
  end

  // Horizontal/vertical raster counters, advanced once per pixel.
  always_ff @(posedge CLOCKINPUT) begin
    if (!PLD_RESET_N) begin
      x <= '0;
      y <= '0;
    end else if (ce) begin
      if (at_last_x) begin
        x <= '0;
        y <= at_last_y ? '0 : y + CW'(1);
      end else begin
        x <= x + CW'(1);
      end
    end
  end

  // Sync/blank delay line; the last element drives the DAC controls.
  always_ff @(posedge CLOCKINPUT) begin
    if (!PLD_RESET_N) begin
      for (int i = 0; i < int'(PIPE); i++) pipe_q[i] <= IDLE_LVL;
    end else if (ce) begin
      pipe_q[0] <= lvl_c;
      for (int i = 1; i < int'(PIPE); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vif.pix_ce      = ce;
  assign vif.x           = x;
  assign vif.y           = y;
  assign vif.active      = act_c;
  assign vif.line_start  = ce && (x == '0);
  assign vif.frame_start = ce && (x == '0) && (y == '0);
  assign vif.vga_HSYNC   = pipe_q[LAST][2];
  assign vif.vga_VSYNC   = pipe_q[LAST][1];
  assign vif.vga_BLANK_n = pipe_q[LAST][0];
  assign vif.vga_CLOCK   = vga_clk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (active-low syncs with
// divide-by-2 / 2-deep pipe, and active-high syncs with divide-by-4 / 1-deep
// pipe) checked every cycle against a pixel-index reference model.
module tb_vga_timing_gen;

  localparam int unsigned CW = 8;

  localparam int unsigned A_HA = 8, A_HFP = 2, A_HS = 3, A_HBP = 2;
  localparam int unsigned A_VA = 5, A_VFP = 1, A_VS = 2, A_VBP = 1;
  localparam int unsigned A_DIV = 2, A_PIPE = 2;
  localparam bit          A_HP = 1'b0, A_VP = 1'b0;

  localparam int unsigned B_HA = 4, B_HFP = 1, B_HS = 1, B_HBP = 1;
  localparam int unsigned B_VA = 3, B_VFP = 1, B_VS = 1, B_VBP = 1;
  localparam int unsigned B_DIV = 4, B_PIPE = 1;
  localparam bit          B_HP = 1'b1, B_VP = 1'b1;

  logic clk;
  logic rst_n;

  vga_timing_gen_if #(.CW(CW)) ifa ();
  vga_timing_gen_if #(.CW(CW)) ifb ();

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .HS_POL(A_HP), .VS_POL(A_VP), .CLK_DIV(A_DIV), .PIPE(A_PIPE), .CW(CW)
  ) dut_a (
    .CLOCKINPUT(clk),
    .PLD_RESET_N(rst_n),
    .vif(ifa)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .HS_POL(B_HP), .VS_POL(B_VP), .CLK_DIV(B_DIV), .PIPE(B_PIPE), .CW(CW)
  ) dut_b (
    .CLOCKINPUT(clk),
    .PLD_RESET_N(rst_n),
    .vif(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model parameters, per instance (0 = a, 1 = b).
  int ht[2], vt[2], ha[2], va[2], hs0[2], hs1[2], vs0[2], vs1[2], dv[2], pd[2];
  bit hp[2], vp[2];

  // Model state: phase within the pixel, pixel index in the frame, and the
  // pixel indices held in the output delay line (-1 = reset/idle).
  int ph[2], pix[2];
  int hist[2][4];

  int checks   = 0;
  int failures = 0;
  int gcyc     = 0;

  logic          s_ce[2], s_ls[2], s_fs[2], s_act[2];
  logic          s_hs[2], s_vs[2], s_bl[2], s_clk[2];
  logic [CW-1:0] s_x[2], s_y[2];
  int            n_ce[2], n_ls[2], n_fs[2];
  int            fs_t[2][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input logic en, input logic rn);
    if (!rn) begin
      ph[i]  = 0;
      pix[i] = 0;
      for (int k = 0; k < 4; k++) hist[i][k] = -1;
    end else if (en) begin
      if (ph[i] == dv[i] - 1) begin
        for (int k = pd[i] - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = pix[i];
        pix[i]     = (pix[i] + 1) % (ht[i] * vt[i]);
        ph[i]      = 0;
      end else begin
        ph[i]++;
      end
    end
  endtask

  task automatic check_one(input int i, input string n, input logic en);
    int ex, ey, q, qx, qy;
    logic ece, ehs, evs, ebl;
    ex  = pix[i] % ht[i];
    ey  = pix[i] / ht[i];
    ece = en && (ph[i] == dv[i] - 1);
    q   = hist[i][pd[i] - 1];
    if (q < 0) begin
      ehs = !hp[i];
      evs = !vp[i];
      ebl = 1'b0;
    end else begin
      qx  = q % ht[i];
      qy  = q / ht[i];
      ehs = (qx >= hs0[i] && qx < hs1[i]) ? hp[i] : !hp[i];
      evs = (qy >= vs0[i] && qy < vs1[i]) ? vp[i] : !vp[i];
      ebl = (qx < ha[i]) && (qy < va[i]);
    end
    chk({n, ".x"}, 32'(s_x[i]), 32'(ex));
    chk({n, ".y"}, 32'(s_y[i]), 32'(ey));
    chk({n, ".active"}, 32'(s_act[i]), 32'((ex < ha[i]) && (ey < va[i])));
    chk({n, ".pix_ce"}, 32'(s_ce[i]), 32'(ece));
    chk({n, ".line_start"}, 32'(s_ls[i]), 32'(ece && ex == 0));
    chk({n, ".frame_start"}, 32'(s_fs[i]), 32'(ece && ex == 0 && ey == 0));
    chk({n, ".vga_CLOCK"}, 32'(s_clk[i]), 32'(ph[i] >= dv[i] / 2));
    chk({n, ".vga_HSYNC"}, 32'(s_hs[i]), 32'(ehs));
    chk({n, ".vga_VSYNC"}, 32'(s_vs[i]), 32'(evs));
    chk({n, ".vga_BLANK_n"}, 32'(s_bl[i]), 32'(ebl));
    if (s_ce[i] === 1'b1) n_ce[i]++;
    if (s_ls[i] === 1'b1) n_ls[i]++;
    if (s_fs[i] === 1'b1) begin
      if (n_fs[i] < 2) fs_t[i][n_fs[i]] = gcyc;
      n_fs[i]++;
    end
  endtask

  task automatic check_all();
    s_ce[0] = ifa.pix_ce;  s_ls[0] = ifa.line_start; s_fs[0] = ifa.frame_start;
    s_act[0] = ifa.active; s_hs[0] = ifa.vga_HSYNC;  s_vs[0] = ifa.vga_VSYNC;
    s_bl[0] = ifa.vga_BLANK_n; s_clk[0] = ifa.vga_CLOCK; s_x[0] = ifa.x; s_y[0] = ifa.y;
    s_ce[1] = ifb.pix_ce;  s_ls[1] = ifb.line_start; s_fs[1] = ifb.frame_start;
    s_act[1] = ifb.active; s_hs[1] = ifb.vga_HSYNC;  s_vs[1] = ifb.vga_VSYNC;
    s_bl[1] = ifb.vga_BLANK_n; s_clk[1] = ifb.vga_CLOCK; s_x[1] = ifb.x; s_y[1] = ifb.y;
    check_one(0, "a", ifa.enable);
    check_one(1, "b", ifb.enable);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then return just after it so new inputs are driven mid-cycle.
  task automatic cyc();
    @(negedge clk);
    gcyc++;
    check_all();
    @(posedge clk);
    model_step(0, ifa.enable, rst_n);
    model_step(1, ifb.enable, rst_n);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_ce[i] = 0; n_ls[i] = 0; n_fs[i] = 0;
      fs_t[i][0] = 0; fs_t[i][1] = 0;
    end
  endtask

  // Release reset with enable high and check the first pixel strobe timing.
  task automatic release_check();
    int first[2];
    first[0] = 0;
    first[1] = 0;
    clear_counts();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 1) begin
        chk("a.rst_x", 32'(s_x[0]), 0);
        chk("a.rst_y", 32'(s_y[0]), 0);
        chk("a.rst_blank_n", 32'(s_bl[0]), 0);
        chk("a.rst_hsync", 32'(s_hs[0]), 1);
        chk("a.rst_vsync", 32'(s_vs[0]), 1);
        chk("b.rst_hsync", 32'(s_hs[1]), 0);
        chk("b.rst_vsync", 32'(s_vs[1]), 0);
      end
      for (int i = 0; i < 2; i++) begin
        if (first[i] == 0 && s_ce[i] === 1'b1) begin
          first[i] = k;
          chk(i == 0 ? "a.first_frame_start" : "b.first_frame_start", 32'(s_fs[i]), 1);
        end
      end
    end
    chk("a.first_ce_cycle", 32'(first[0]), 2);
    chk("b.first_ce_cycle", 32'(first[1]), 4);
  endtask

  initial begin
    int base_a, base_b, guard, ce_n;

    ht[0] = A_HA + A_HFP + A_HS + A_HBP; vt[0] = A_VA + A_VFP + A_VS + A_VBP;
    ha[0] = A_HA; va[0] = A_VA;
    hs0[0] = A_HA + A_HFP; hs1[0] = A_HA + A_HFP + A_HS;
    vs0[0] = A_VA + A_VFP; vs1[0] = A_VA + A_VFP + A_VS;
    dv[0] = A_DIV; pd[0] = A_PIPE; hp[0] = A_HP; vp[0] = A_VP;
    ht[1] = B_HA + B_HFP + B_HS + B_HBP; vt[1] = B_VA + B_VFP + B_VS + B_VBP;
    ha[1] = B_HA; va[1] = B_VA;
    hs0[1] = B_HA + B_HFP; hs1[1] = B_HA + B_HFP + B_HS;
    vs0[1] = B_VA + B_VFP; vs1[1] = B_VA + B_VFP + B_VS;
    dv[1] = B_DIV; pd[1] = B_PIPE; hp[1] = B_HP; vp[1] = B_VP;

    rst_n      = 1'b0;
    ifa.enable = 1'b1;
    ifb.enable = 1'b1;
    clear_counts();

    // Initialise DUT and model before any comparison is made.
    repeat (2) begin
      @(posedge clk);
      model_step(0, ifa.enable, rst_n);
      model_step(1, ifb.enable, rst_n);
      #1;
    end
    repeat (2) cyc();

    // Release with enable high; run 540 cycles total and count strobes.
    release_check();
    repeat (532) cyc();
    for (int i = 0; i < 2; i++) begin
      ce_n = 540 / dv[i];
      chk(i == 0 ? "a.pix_ce_count" : "b.pix_ce_count", 32'(n_ce[i]), 32'(ce_n));
      chk(i == 0 ? "a.frame_count" : "b.frame_count", 32'(n_fs[i]), 32'((ce_n - 1) / (ht[i] * vt[i]) + 1));
      chk(i == 0 ? "a.line_count" : "b.line_count", 32'(n_ls[i]), 32'((ce_n - 1) / ht[i] + 1));
      chk(i == 0 ? "a.frame_period" : "b.frame_period", 32'(fs_t[i][1] - fs_t[i][0]),
          32'(ht[i] * vt[i] * dv[i]));
    end

    // Freeze both generators at a known raster position of instance a.
    guard = 0;
    while (!((pix[0] % ht[0]) == 5 && (pix[0] / ht[0]) == 3) && guard < 400) begin
      cyc();
      guard++;
    end
    chk("a.reach_freeze_pos", 32'(guard < 400), 1);
    base_a = n_ce[0];
    base_b = n_ce[1];
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    repeat (50) cyc();
    chk("a.frozen_x", 32'(s_x[0]), 5);
    chk("a.frozen_y", 32'(s_y[0]), 3);
    chk("a.frozen_ce", 32'(n_ce[0] - base_a), 0);
    chk("b.frozen_ce", 32'(n_ce[1] - base_b), 0);
    ifa.enable = 1'b1;
    ifb.enable = 1'b1;
    guard = 0;
    while (n_ce[0] == base_a && guard < 8) begin
      cyc();
      guard++;
    end
    chk("a.resume_x", 32'(s_x[0]), 5);
    chk("a.resume_y", 32'(s_y[0]), 3);

    // One-cycle reset in the middle of a line, then the normal restart.
    repeat (23) cyc();
    rst_n = 1'b0;
    cyc();
    release_check();

    // Random enable gaps and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      ifa.enable = ($urandom_range(0, 9) != 0);
      ifb.enable = ($urandom_range(0, 9) != 0);
      rst_n      = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the board top level. It derives a pixel-clock enable from `CLOCKINPUT` and runs horizontal/vertical counters. It drives `vga_HSYNC`, `vga_VSYNC`, `vga_BLANK_n` and `vga_CLOCK`, and exports pixel coordinates to the pixel source (SDRAM frame reader or pattern logic). It replaces fixed-640x480 timing with per-field timing parameters, programmable sync polarity, a clock divider and a sync/blank delay pipeline that matches downstream RGB latency.

## Interface
- Clock `CLOCKINPUT`; reset `PLD_RESET_N`: synchronous, active-low, single clock domain.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HS_POL`, 0: asserted level of `vga_HSYNC` (0 = active-low).
- `VS_POL`, 0: asserted level of `vga_VSYNC`.
- `CLK_DIV`, 2: `CLOCKINPUT` cycles per pixel; must be even and ≥2.
- `PIPE`, 2: delay of sync/blank outputs, in pixel periods; ≥1.
- `CW`, 12: width of the coordinate outputs.
- `CLOCKINPUT` in 1: system clock.
- `PLD_RESET_N` in 1: synchronous active-low reset.
- `enable` in 1: run; when low, the timing generator freezes.
- `pix_ce` out 1: one-cycle pixel enable.
- `x` out CW: horizontal counter value.
- `y` out CW: vertical counter value.
- `active` out 1: (x,y) lies inside the visible area.
- `line_start` out 1: pulse when x=0.
- `frame_start` out 1: pulse when x=0 and y=0.
- `vga_HSYNC` out 1: delayed horizontal sync.
- `vga_VSYNC` out 1: delayed vertical sync.
- `vga_BLANK_n` out 1: delayed blanking signal; 1 = visible.
- `vga_CLOCK` out 1: pixel clock to the DAC.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is formed the same way from the vertical parameters. Both totals must be < 2^CW.
- Divider `d` counts 0..CLK_DIV-1, advancing each cycle while `enable` is high. `pix_ce` = (d == CLK_DIV-1) && `enable`.
- `vga_CLOCK` is registered: high while d ≥ CLK_DIV/2. Its rising edge therefore falls mid-pixel.
- On `pix_ce`:
  - x increments. When x == H_TOTAL-1, x wraps to 0 and y increments.
  - When y == V_TOTAL-1 and x wraps, y wraps to 0.
- Horizontal region order is active → front porch → sync → back porch; vertical uses the same order.
  - Horizontal sync is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - Vertical sync is asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- `active` = (x < H_ACTIVE) && (y < V_ACTIVE), decoded combinationally from the registered x and y.
- `line_start` = `pix_ce` && x==0. `frame_start` = `pix_ce` && x==0 && y==0.
- Sync/blank delay pipeline:
  - A PIPE-deep shift register of {hs, vs, active} shifts only on `pix_ce`.
  - The output stage drives `vga_HSYNC` = hs ? HS_POL : !HS_POL, `vga_VSYNC` likewise with VS_POL, and `vga_BLANK_n` = active.
  - This stage is the shift register's final element.
- `enable` low:
  - d, x, y, the pipeline and `vga_CLOCK` all hold their values.
  - `pix_ce`, `line_start` and `frame_start` are 0.
  - Resuming continues from the held position.
- Reset, including mid-frame:
  - d=0, x=0, y=0, `vga_CLOCK`=0.
  - `pix_ce`, `line_start` and `frame_start` = 0.
  - Every pipeline stage is set to inactive: `vga_HSYNC`=!HS_POL, `vga_VSYNC`=!VS_POL, `vga_BLANK_n`=0.

## Timing
- With `enable` high from reset release, the first `pix_ce` occurs on the CLK_DIV-th cycle after release, with x=0, y=0 and `frame_start`=1.
- x, y and `active` are stable for the whole pixel period and change on the clock edge that ends `pix_ce`.
- The sync/blank outputs for the pixel presented at `pix_ce` number k become valid after the edge ending `pix_ce` number k+PIPE-1. They stay valid for one pixel period.
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV cycles; with defaults this is 840000 cycles.

## Test plan
- Reset release, defaults, `enable`=1 → first `pix_ce` on cycle 2 with x=0, y=0 and `frame_start`=1.
  - `frame_start` repeats every 840000 cycles.
  - Exactly 420000 `pix_ce` pulses occur per frame.
- Defaults, with a check of the outputs against (x,y) delayed by PIPE=2 pixels:
  - `vga_HSYNC` is low for exactly 96 pixel periods per line, beginning at the output corresponding to x=656.
  - `vga_VSYNC` is low for lines 490–491.
  - `vga_BLANK_n` is high for 640 pixels on each of lines 0–479 and low everywhere else.
- HS_POL=1, VS_POL=1, CLK_DIV=4, PIPE=1 → syncs are high-true, pixel period is 4 cycles and `vga_CLOCK` has a 50% duty cycle. Sync transitions occur one edge after the matching `pix_ce`.
- Small parameters (H=4/1/1/1, V=3/1/1/1) → x wraps 0..6 and y wraps 0..5. `line_start` fires 6 times per `frame_start`.
- Drop `enable` at x=300, y=100 for 50 cycles → x, y and the outputs are frozen and no `pix_ce` occurs. Resume continues at x=300, y=100.
- Assert `PLD_RESET_N`=0 for 1 cycle mid-line → on the next cycle the reset values hold:
  - x=0, y=0, `vga_BLANK_n`=0, `vga_HSYNC`=1, `vga_VSYNC`=1.
  - The restart then matches the first test.
